// File: rtl/monitor_de_registradores.sv
// Register-file monitor: scans every register through a read port and compares it against a loadable expected table.
// Optional build macro MONITOR_MASK_EN adds a per-entry mask bit that excludes entries from the comparison.
module monitor_de_registradores #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int RD_LAT   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inicio_i,
   input  logic              exp_we_i,
   input  logic [ADDR_W-1:0] exp_addr_i,
   input  logic [DATA_W-1:0] exp_data_i,
`ifdef MONITOR_MASK_EN
   input  logic              exp_mask_i,
`endif
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              ocupado_o,
   output logic              concluido_o,
   output logic              aprovado_o,
   output logic [ADDR_W:0]   num_erros_o,
   output logic [ADDR_W-1:0] primeiro_erro_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LEITURA = 2'd1,
      FIM     = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [1:0]        LAT_LAST   = 2'(RD_LAT);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [1:0]          lat_q, lat_d;
   logic [ADDR_W:0]     numErros_q, numErros_d;
   logic [ADDR_W-1:0]   primeiroErro_q, primeiroErro_d;
   logic                aprovado_q, aprovado_d;
   logic [DATA_W-1:0]   expTable_q [NUM_REGS];

   logic                tableWe;
   logic                lastCycle;
   logic                lastIdx;
   logic                mismatch;

   // Entry 0 models x0 and is never written, so it stays at its reset value of zero.
   assign tableWe = exp_we_i && (state_q == IDLE) && (exp_addr_i != '0)
                    && ({1'b0, exp_addr_i} < NUM_REGS_W);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            expTable_q[i] <= '0;
         end
      end else if (tableWe) begin
         expTable_q[exp_addr_i] <= exp_data_i;
      end
   end

`ifdef MONITOR_MASK_EN
   logic [NUM_REGS-1:0] mask_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         mask_q <= '0;
      end else if (tableWe) begin
         mask_q[exp_addr_i] <= exp_mask_i;
      end
   end

   assign mismatch = (rd_data_i != expTable_q[idx_q]) && !mask_q[idx_q];
`else
   assign mismatch = (rd_data_i != expTable_q[idx_q]);
`endif

   // Each index is held for RD_LAT+1 cycles; the compare happens on the last of them.
   assign lastCycle = (lat_q == LAT_LAST);
   assign lastIdx   = (idx_q == LAST_IDX);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         lat_q          <= '0;
         numErros_q     <= '0;
         primeiroErro_q <= '0;
         aprovado_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         lat_q          <= lat_d;
         numErros_q     <= numErros_d;
         primeiroErro_q <= primeiroErro_d;
         aprovado_q     <= aprovado_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (inicio_i) state_d = LEITURA;
         LEITURA: if (lastCycle && lastIdx) state_d = FIM;
         FIM:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Index stops at the last register so rd_addr keeps that value while idle.
   always_comb begin
      idx_d          = idx_q;
      lat_d          = lat_q;
      numErros_d     = numErros_q;
      primeiroErro_d = primeiroErro_q;
      aprovado_d     = aprovado_q;
      case (state_q)
         IDLE: begin
            if (inicio_i) begin
               idx_d          = '0;
               lat_d          = '0;
               numErros_d     = '0;
               primeiroErro_d = '0;
               aprovado_d     = 1'b0;
            end
         end
         LEITURA: begin
            if (lastCycle) begin
               lat_d = '0;
               if (mismatch) begin
                  numErros_d = numErros_q + (ADDR_W + 1)'(1);
                  if (numErros_q == '0) begin
                     primeiroErro_d = idx_q;
                  end
               end
               if (!lastIdx) begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         FIM: begin
            aprovado_d = (numErros_q == '0);
         end
         default: ;
      endcase
   end

   always_comb begin
      ocupado_o   = (state_q != IDLE);
      concluido_o = (state_q == FIM);
   end

   assign rd_addr_o       = idx_q;
   assign aprovado_o      = aprovado_q;
   assign num_erros_o     = numErros_q;
   assign primeiro_erro_o = primeiroErro_q;

endmodule

// File: tb/tb_monitor_de_registradores.sv
// Directed bench for monitor_de_registradores: a 32-entry, latency-1 instance and a 16-entry, latency-0 instance.
// Mask checks are compiled in only when MONITOR_MASK_EN is defined.
module tb_monitor_de_registradores;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        inicioA, expWeA, expMaskA;
   logic [4:0]  expAddrA;
   logic [31:0] expDataA;
   logic [4:0]  rdAddrA;
   logic [31:0] rdDataA;
   logic        ocupadoA, concluidoA, aprovadoA;
   logic [5:0]  numErrosA;
   logic [4:0]  primeiroErroA;
   logic [31:0] rfA [32];

   logic        inicioB, expWeB, expMaskB;
   logic [4:0]  expAddrB;
   logic [31:0] expDataB;
   logic [4:0]  rdAddrB;
   logic [31:0] rdDataB;
   logic        ocupadoB, concluidoB, aprovadoB;
   logic [5:0]  numErrosB;
   logic [4:0]  primeiroErroB;
   logic [31:0] rfB [16];

   int checks   = 0;
   int failures = 0;
   int cyc;
   int pulses;

   monitor_de_registradores #(.NUM_REGS(32), .DATA_W(32), .ADDR_W(5), .RD_LAT(1)) dutA (
      .clk_i(clk), .rst_i(rst), .inicio_i(inicioA), .exp_we_i(expWeA),
      .exp_addr_i(expAddrA), .exp_data_i(expDataA),
`ifdef MONITOR_MASK_EN
      .exp_mask_i(expMaskA),
`endif
      .rd_addr_o(rdAddrA), .rd_data_i(rdDataA), .ocupado_o(ocupadoA),
      .concluido_o(concluidoA), .aprovado_o(aprovadoA),
      .num_erros_o(numErrosA), .primeiro_erro_o(primeiroErroA)
   );

   monitor_de_registradores #(.NUM_REGS(16), .DATA_W(32), .ADDR_W(5), .RD_LAT(0)) dutB (
      .clk_i(clk), .rst_i(rst), .inicio_i(inicioB), .exp_we_i(expWeB),
      .exp_addr_i(expAddrB), .exp_data_i(expDataB),
`ifdef MONITOR_MASK_EN
      .exp_mask_i(expMaskB),
`endif
      .rd_addr_o(rdAddrB), .rd_data_i(rdDataB), .ocupado_o(ocupadoB),
      .concluido_o(concluidoB), .aprovado_o(aprovadoB),
      .num_erros_o(numErrosB), .primeiro_erro_o(primeiroErroB)
   );

   // Register file A answers one cycle after the address; B answers combinationally.
   always @(posedge clk) rdDataA <= rfA[rdAddrA];
   assign rdDataB = rfB[rdAddrB[3:0]];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data, input logic mask);
      expWeA   = 1'b1;
      expAddrA = addr;
      expDataA = data;
      expMaskA = mask;
      stepCycle();
      expWeA   = 1'b0;
   endtask

   // Starts a scan on A and returns the cycle (inicio edge = 0) in which concluido is seen, -1 on timeout.
   // With midActions set, a table write and a second inicio are issued in cycle 10.
   task automatic runScanA(input bit midActions, output int found);
      inicioA = 1'b1;
      stepCycle();
      inicioA = 1'b0;
      expWeA  = 1'b0;
      found   = -1;
      checkOutput("A_ocupado_scan", ocupadoA, 1);
      for (int n = 1; n <= 300; n++) begin
         if (concluidoA) begin
            found = n;
            break;
         end
         if (midActions && n == 10) begin
            expWeA   = 1'b1;
            expAddrA = 5'd5;
            expDataA = 32'd99;
            inicioA  = 1'b1;
         end
         stepCycle();
         expWeA  = 1'b0;
         inicioA = 1'b0;
      end
      stepCycle();
      checkOutput("A_concluido_one_cycle", concluidoA, 0);
      checkOutput("A_ocupado_after", ocupadoA, 0);
   endtask

   task automatic runScanB(output int found);
      inicioB = 1'b1;
      stepCycle();
      inicioB = 1'b0;
      found   = -1;
      for (int n = 1; n <= 200; n++) begin
         if (concluidoB) begin
            found = n;
            break;
         end
         stepCycle();
      end
      stepCycle();
      checkOutput("B_concluido_one_cycle", concluidoB, 0);
   endtask

   initial begin
      rst = 1'b0;
      inicioA = 0; expWeA = 0; expMaskA = 0; expAddrA = '0; expDataA = '0;
      inicioB = 0; expWeB = 0; expMaskB = 0; expAddrB = '0; expDataB = '0;
      for (int i = 0; i < 32; i++) rfA[i] = '0;
      for (int i = 0; i < 16; i++) rfB[i] = '0;
      stepCycle();
      stepCycle();
      checkOutput("reset_ocupado", ocupadoA, 0);
      checkOutput("reset_concluido", concluidoA, 0);
      checkOutput("reset_aprovado", aprovadoA, 0);
      checkOutput("reset_num_erros", numErrosA, 0);
      checkOutput("reset_primeiro_erro", primeiroErroA, 0);
      checkOutput("reset_rd_addr", rdAddrA, 0);
      rst = 1'b1;
      stepCycle();

      $display("[TB] all-zero scan");
      runScanA(1'b0, cyc);
      checkOutput("zero_concluido_cycle", cyc, 65);
      checkOutput("zero_aprovado", aprovadoA, 1);
      checkOutput("zero_num_erros", numErrosA, 0);
      checkOutput("zero_primeiro_erro", primeiroErroA, 0);
      checkOutput("zero_rd_addr_hold", rdAddrA, 31);

      $display("[TB] matching table");
      applyStimulus(5'd1, 32'd7, 1'b0);
      applyStimulus(5'd2, 32'd14, 1'b0);
      applyStimulus(5'd3, 32'd7, 1'b0);
      applyStimulus(5'd4, 32'd0, 1'b0);
      rfA[1] = 32'd7; rfA[2] = 32'd14; rfA[3] = 32'd7;
      runScanA(1'b0, cyc);
      checkOutput("match_aprovado", aprovadoA, 1);
      checkOutput("match_num_erros", numErrosA, 0);

      $display("[TB] two mismatches");
      rfA[2] = 32'd15; rfA[4] = 32'd9;
      runScanA(1'b0, cyc);
      checkOutput("mis_aprovado", aprovadoA, 0);
      checkOutput("mis_num_erros", numErrosA, 2);
      checkOutput("mis_primeiro_erro", primeiroErroA, 2);
      for (int i = 0; i < 5; i++) stepCycle();
      checkOutput("mis_num_erros_held", numErrosA, 2);
      checkOutput("mis_primeiro_held", primeiroErroA, 2);

      $display("[TB] x0 write, write and inicio during scan");
      rfA[2] = 32'd14; rfA[4] = 32'd0;
      applyStimulus(5'd0, 32'd5, 1'b0);
      runScanA(1'b1, cyc);
      checkOutput("busy_concluido_cycle", cyc, 65);
      checkOutput("busy_aprovado", aprovadoA, 1);
      checkOutput("busy_num_erros", numErrosA, 0);

      $display("[TB] write and inicio together");
      rfA[6]   = 32'd33;
      expWeA   = 1'b1;
      expAddrA = 5'd6;
      expDataA = 32'd33;
      expMaskA = 1'b0;
      runScanA(1'b0, cyc);
      checkOutput("same_cycle_aprovado", aprovadoA, 1);
      checkOutput("same_cycle_num_erros", numErrosA, 0);

      $display("[TB] reset mid-scan");
      rfA[2] = 32'd15;
      inicioA = 1'b1;
      stepCycle();
      inicioA = 1'b0;
      for (int n = 1; n < 20; n++) stepCycle();
      checkOutput("pre_reset_num_erros", numErrosA, 1);
      rst = 1'b0;
      stepCycle();
      rst = 1'b1;
      checkOutput("midrst_ocupado", ocupadoA, 0);
      checkOutput("midrst_num_erros", numErrosA, 0);
      checkOutput("midrst_rd_addr", rdAddrA, 0);
      pulses = 0;
      for (int n = 0; n < 80; n++) begin
         if (concluidoA) pulses++;
         stepCycle();
      end
      checkOutput("midrst_no_concluido", pulses, 0);
      for (int i = 0; i < 32; i++) rfA[i] = '0;
      runScanA(1'b0, cyc);
      checkOutput("cleared_concluido_cycle", cyc, 65);
      checkOutput("cleared_aprovado", aprovadoA, 1);
      checkOutput("cleared_num_erros", numErrosA, 0);

      $display("[TB] 16 registers, zero latency");
      expWeB = 1'b1; expAddrB = 5'd3; expDataB = 32'd5;
      stepCycle();
      expWeB = 1'b0;
      rfB[3] = 32'd5; rfB[7] = 32'd1; rfB[9] = 32'd2;
      runScanB(cyc);
      checkOutput("B_concluido_cycle", cyc, 17);
      checkOutput("B_aprovado", aprovadoB, 0);
      checkOutput("B_num_erros", numErrosB, 2);
      checkOutput("B_primeiro_erro", primeiroErroB, 7);

`ifdef MONITOR_MASK_EN
      $display("[TB] masked entry");
      applyStimulus(5'd4, 32'd0, 1'b1);
      rfA[4] = 32'd9;
      runScanA(1'b0, cyc);
      checkOutput("mask_aprovado", aprovadoA, 1);
      checkOutput("mask_num_erros", numErrosA, 0);
      applyStimulus(5'd4, 32'd0, 1'b0);
      runScanA(1'b0, cyc);
      checkOutput("unmask_num_erros", numErrosA, 1);
      checkOutput("unmask_primeiro_erro", primeiroErroA, 4);
      checkOutput("unmask_aprovado", aprovadoA, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/monitor_de_registradores.md
Name: monitor_de_registradores

Overview:
- Self-checking register-file monitor for the processor bench and on-chip debug.
- On a start pulse it scans all architectural registers through a read port and compares each against a loadable table of expected values.
- Reports pass/fail, mismatch count and index of first mismatch.
- Replaces hand-written per-register display/compare code; generalised in register count, data width and read latency.

Parameters:
NUM_REGS, 32, number of registers scanned (indices 0..NUM_REGS-1)
DATA_W, 32, register data width
ADDR_W, 5, index width; must satisfy 2**ADDR_W >= NUM_REGS
RD_LAT, 1, register-file read latency in cycles (legal 0..2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
inicio  in  1  start pulse; sampled only in IDLE
exp_we  in  1  expected-table write enable
exp_addr  in  ADDR_W  expected-table write index
exp_data  in  DATA_W  expected value to write
rd_addr  out  ADDR_W  register-file read index
rd_data  in  DATA_W  register-file read data, valid RD_LAT cycles after rd_addr
ocupado  out  1  high while scanning (LEITURA and FIM)
concluido  out  1  one-cycle pulse at end of scan
aprovado  out  1  1 when last scan had zero mismatches
num_erros  out  ADDR_W+1  mismatch count of last scan
primeiro_erro  out  ADDR_W  lowest mismatching index of last scan; 0 if none

Behaviour:
- Reset (rst=0 at edge): state IDLE, rd_addr=0, ocupado=0, concluido=0, aprovado=0, num_erros=0, primeiro_erro=0, all table entries=0, latency counter=0.
- Table writes: exp_we=1 in IDLE writes exp_data to entry exp_addr at the edge. Writes are ignored while ocupado=1, for exp_addr>=NUM_REGS, and for exp_addr=0; entry 0 is hardwired to 0 (x0).
- FSM:
  - IDLE: inicio=1 at edge -> LEITURA; idx=0; num_erros=0; primeiro_erro=0; aprovado=0.
  - LEITURA: rd_addr=idx. Each index occupies RD_LAT+1 cycles. On the final cycle of the index, rd_data is compared with entry idx. On mismatch, num_erros is incremented; if it was 0, primeiro_erro is set to idx. Then idx increments. After idx=NUM_REGS-1 -> FIM.
  - FIM: concluido=1 for exactly one cycle; aprovado=(num_erros==0) registered at this edge; next state IDLE.
- Timing: with inicio sampled at edge 0, concluido is high in cycle NUM_REGS*(RD_LAT+1)+1. Defaults give cycle 65.
- RD_LAT=0: rd_data is treated as combinational; compare happens in the same cycle as rd_addr.
- inicio while ocupado=1: ignored, no restart.
- inicio and exp_we in the same IDLE cycle: the write is performed and the scan starts; the scan uses the new value.
- num_erros never exceeds NUM_REGS (width ADDR_W+1); no saturation logic.
- Results (aprovado, num_erros, primeiro_erro) hold until the next inicio is accepted.
- rst=0 mid-scan: immediate return to reset state, including clearing the table; no concluido pulse.
- rd_addr holds its last value in IDLE.

Optional Feature:
- Macro MONITOR_MASK_EN.
- Defined:
  - Adds input exp_mask (1 bit) written into a per-entry mask bit alongside exp_data on every accepted table write.
  - Masked entries (bit=1) are still read but never counted as mismatches and never set primeiro_erro.
  - All mask bits reset to 0. Entry 0 is never masked.
- Not defined: no exp_mask port, no mask storage; every entry is compared.

Test Plan:
- Reset, then inicio with table all-zero and register file all-zero -> concluido at cycle 65, aprovado=1, num_erros=0, primeiro_erro=0.
- Load entries 1=7, 2=14, 3=7, 4=0; register file x1=7, x2=14, x3=7, rest 0 -> aprovado=1, num_erros=0.
- Same table, register file x2=15 and x4=9 -> aprovado=0, num_erros=2, primeiro_erro=2.
- Write exp_addr=0 with exp_data=5, register file x0=0 -> entry 0 stays 0, no mismatch. Write during scan -> ignored; second inicio mid-scan -> no restart, concluido still at cycle 65.
- rst=0 at cycle 20 of a scan -> ocupado=0, concluido never pulses, table cleared. Rerun with RD_LAT=0 and NUM_REGS=16 -> concluido at cycle 17.
- MONITOR_MASK_EN defined: entry 4 masked, x4=9 mismatch -> aprovado=1, num_erros=0. Without mask bit set -> num_erros=1, primeiro_erro=4.
